dmem_responder: RTL

Data-memory responder for the multicycle RV64 core: the memory-side end of the core's load/store request interface. Accepts one request at a time over a valid/ready handshake and waits a programmable latency. Performs byte/half/word/doubleword stores with lane masking, or loads with sign/zero extension. Returns a response over a second valid/ready handshake. Sits beside `principal`, replacing an ideal single-cycle data memory so the control unit's memory-wait states are actually exercised.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side types: access size, responder state, size helper.
// Imported by the data-memory responder and its lane aligner.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic [3:0] size_bytes(size_t sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extended load value, byte enables, store word.
// Ports: size/lane/is_unsigned select the access; rword/wdata in; rdata/be/wword out.
module dmem_lane_align
    import mem_pkg::*;
(
    input  size_t       size,
    input  logic [2:0]  lane,
    input  logic        is_unsigned,
    input  logic [63:0] rword,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wword
);

    logic [5:0]  sh;
    logic [63:0] rsh;
    logic [7:0]  be_base;

    assign sh = {lane, 3'b000};

    always_comb begin
        rsh     = rword >> sh;
        wword   = wdata << sh;
        rdata   = rsh;
        be_base = 8'hFF;
        unique case (size)
            SZ_B: begin
                be_base = 8'h01;
                rdata   = is_unsigned ? {56'd0, rsh[7:0]}
                                      : {{56{rsh[7]}}, rsh[7:0]};
            end
            SZ_H: begin
                be_base = 8'h03;
                rdata   = is_unsigned ? {48'd0, rsh[15:0]}
                                      : {{48{rsh[15]}}, rsh[15:0]};
            end
            SZ_W: begin
                be_base = 8'h0F;
                rdata   = is_unsigned ? {32'd0, rsh[31:0]}
                                      : {{32{rsh[31]}}, rsh[31:0]};
            end
            SZ_D: begin
                be_base = 8'hFF;
                rdata   = rsh;
            end
        endcase
        be = be_base << lane;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable latency, registered response.
// Ports: clk/rst; req_* valid/ready request; rsp_* valid/ready response; busy.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    size_t       size_q, size_d;
    logic        uns_q, uns_d;
    logic [63:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [63:0] mem [DEPTH];
    logic [AW-1:0] widx;
    logic [63:0] rword;
    logic [63:0] ld_data;
    logic [63:0] wword;
    logic [7:0]  be;
    logic [3:0]  nbytes;
    logic [2:0]  amask;
    logic        acc_err;
    logic        mem_we;

    assign widx   = addr_q[3+AW-1:3];
    assign rword  = mem[widx];
    assign nbytes = size_bytes(size_q);
    assign amask  = nbytes[2:0] - 3'd1;

    assign acc_err = (|(addr_q[2:0] & amask))
                   | (|addr_q[63:3+AW]);

    dmem_lane_align u_align (
        .size        (size_q),
        .lane        (addr_q[2:0]),
        .is_unsigned (uns_q),
        .rword       (rword),
        .wdata       (wdata_q),
        .rdata       (ld_data),
        .be          (be),
        .wword       (wword)
    );

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // WAIT spans LATENCY+1 cycles, so the access edge (and rsp_valid)
    // lands LATENCY+1 edges after acceptance, including LATENCY=0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = size_t'(req_size);
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    mem_we      = we_q & ~acc_err;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (we_q | acc_err) ? 64'd0
                                                   : ld_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 64'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 64'd0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            wdata_q     <= 64'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

endmodule
